// File: rtl/cam_capture_ctrl.sv
// DVP camera capture engine: synchronises the camera pins into clk, packs byte pairs
// into 16-bit pixels, optionally decimates 2:1 in X/Y and streams pixels to a frame buffer.
module cam_capture_ctrl #(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int DEPTH       = 76800,
    parameter int ADDR_W      = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    input  logic              enable,
    input  logic              decim,
    input  logic              byte_swap,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic [ADDR_W-1:0] pix_count,
    output logic              overflow,
    output logic              busy
);

    // state   | meaning
    // IDLE    | capture disabled
    // WAIT_VS | armed, waiting for vsync falling edge (frame start)
    // ACTIVE  | capturing lines until vsync rises
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_LIM   = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_LIM   = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_t state, state_nxt;

    // {pclk, vsync, href, d} travel together so every stage stays aligned
    logic [10:0] sync_q [SYNC_STAGES];
    logic        pclk_s, vs_s, href_s;
    logic [7:0]  d_s;
    logic        pclk_prev, vs_prev, href_prev;
    logic        samp, vs_fall, vs_rise;

    logic [ADDR_W-1:0] addr;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              phase;
    logic [7:0]        b0;
    logic              decim_q, swap_q;
    logic              start_frame, end_frame;
    logic              capturing, keep, addr_ok;
    logic [15:0]       pix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {cam_pclk, cam_vsync, cam_href, cam_d};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign pclk_s = sync_q[SYNC_STAGES-1][10];
    assign vs_s   = sync_q[SYNC_STAGES-1][9];
    assign href_s = sync_q[SYNC_STAGES-1][8];
    assign d_s    = sync_q[SYNC_STAGES-1][7:0];

    assign samp    = pclk_s & ~pclk_prev;
    assign vs_fall = samp & vs_prev & ~vs_s;
    assign vs_rise = samp & ~vs_prev & vs_s;

    // vsync/href history only advances on sample events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_prev <= 1'b0;
            vs_prev   <= 1'b0;
            href_prev <= 1'b0;
        end else begin
            pclk_prev <= pclk_s;
            if (samp) begin
                vs_prev   <= vs_s;
                href_prev <= href_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (vs_fall) begin
                    state_nxt   = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    end_frame = 1'b1;
                    state_nxt = enable ? WAIT_VS : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign capturing = (state == ACTIVE) && !vs_rise && samp;
    assign keep      = (x < X_LIM) && (y < Y_LIM) && (!decim_q || (!x[0] && !y[0]));
    assign addr_ok   = ({1'b0, addr} < DEPTH_C);
    assign pix       = swap_q ? {d_s, b0} : {b0, d_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            pix_count  <= '0;
            overflow   <= 1'b0;
            addr       <= '0;
            x          <= '0;
            y          <= '0;
            phase      <= 1'b0;
            b0         <= '0;
            decim_q    <= 1'b0;
            swap_q     <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (start_frame) begin
                addr     <= '0;
                x        <= '0;
                y        <= '0;
                phase    <= 1'b0;
                overflow <= 1'b0;
                decim_q  <= decim;
                swap_q   <= byte_swap;
            end else if (end_frame) begin
                frame_done <= 1'b1;
                pix_count  <= addr;
            end else if (capturing) begin
                if (href_s) begin
                    phase <= ~phase;
                    if (!phase) begin
                        b0 <= d_s;
                    end else begin
                        // x saturates at the limit; anything there is dropped anyway
                        if (x < X_LIM) x <= x + 1'b1;
                        if (keep) begin
                            if (addr_ok) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= pix;
                                addr    <= addr + 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                    end
                end else begin
                    phase <= 1'b0;
                    if (href_prev) begin
                        x <= '0;
                        if (x != '0 && y < Y_LIM) y <= y + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: small frames (4x3, depth 12) plus a depth-5
// instance sharing the same camera stimulus to exercise frame-buffer overflow.
module tb_cam_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_d;
    logic        enable, decim, byte_swap;

    logic        wr_en, frame_done, overflow, busy;
    logic [4:0]  wr_addr, pix_count;
    logic [15:0] wr_data;
    logic        wr_en5, frame_done5, overflow5, busy5;
    logic [4:0]  wr_addr5, pix_count5;
    logic [15:0] wr_data5;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cam_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(3), .DEPTH(12), .ADDR_W(5), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_d(cam_d), .enable(enable), .decim(decim),
        .byte_swap(byte_swap), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .pix_count(pix_count), .overflow(overflow), .busy(busy));

    cam_capture_ctrl #(.H_ACTIVE(4), .V_ACTIVE(3), .DEPTH(5), .ADDR_W(5), .SYNC_STAGES(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_d(cam_d), .enable(enable), .decim(decim),
        .byte_swap(byte_swap), .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .frame_done(frame_done5), .pix_count(pix_count5), .overflow(overflow5), .busy(busy5));

    // write/pulse recorder; only this block writes the totals
    int          wr_total = 0, fd_total = 0, wr5_total = 0, fd5_total = 0;
    logic [15:0] wdata [256];
    logic [4:0]  waddr [256];
    logic [4:0]  last5_addr = '0;

    always @(negedge clk) begin
        if (wr_en) begin
            wdata[wr_total[7:0]] <= wr_data;
            waddr[wr_total[7:0]] <= wr_addr;
            wr_total <= wr_total + 1;
        end
        if (frame_done) fd_total <= fd_total + 1;
        if (wr_en5) begin
            last5_addr <= wr_addr5;
            wr5_total  <= wr5_total + 1;
        end
        if (frame_done5) fd5_total <= fd5_total + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one camera pclk period = 8 clk; camera changes data on the falling edge
    task automatic pclk_cyc(input logic vs, input logic hr, input logic [7:0] dd);
        @(negedge clk);
        cam_pclk = 1'b0; cam_vsync = vs; cam_href = hr; cam_d = dd;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] bval;

    task automatic frame_start();
        bval = 8'd1;
        pclk_cyc(1'b1, 1'b0, 8'h00);
        pclk_cyc(1'b1, 1'b0, 8'h00);
        pclk_cyc(1'b0, 1'b0, 8'h00);
        pclk_cyc(1'b0, 1'b0, 8'h00);
        #2;
    endtask

    task automatic send_line(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            pclk_cyc(1'b0, 1'b1, bval);
            bval = bval + 8'd1;
        end
        pclk_cyc(1'b0, 1'b0, 8'h00);
        pclk_cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_end();
        pclk_cyc(1'b1, 1'b0, 8'h00);
        pclk_cyc(1'b1, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        #2;
    endtask

    function automatic logic [15:0] wd(input int k);
        logic [7:0] idx;
        idx = k[7:0];
        return wdata[idx];
    endfunction

    function automatic logic [4:0] wa(input int k);
        logic [7:0] idx;
        idx = k[7:0];
        return waddr[idx];
    endfunction

    int b, f, b5, f5;

    initial begin
        rst_n = 1'b0; cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_d = '0;
        enable = 1'b0; decim = 1'b0; byte_swap = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_frame_done", {31'd0, frame_done}, 0);
        chk("rst_pix_count", {27'd0, pix_count}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("busy_wait_vs", {31'd0, busy}, 1);

        // plain 4x3 frame; depth-5 instance overflows on the same stimulus
        b = wr_total; f = fd_total; b5 = wr5_total; f5 = fd5_total;
        frame_start();
        send_line(8); send_line(8); send_line(8);
        frame_end();
        chk("t1_nwr", wr_total - b, 12);
        for (int i = 0; i < 12; i++) chk("t1_addr", {27'd0, wa(b + i)}, i);
        chk("t1_first", {16'd0, wd(b)}, 32'h0102);
        chk("t1_last", {16'd0, wd(b + 11)}, 32'h1718);
        chk("t1_fdone", fd_total - f, 1);
        chk("t1_pixcnt", {27'd0, pix_count}, 12);
        chk("t1_ovf", {31'd0, overflow}, 0);
        chk("t4_nwr", wr5_total - b5, 5);
        chk("t4_lastaddr", {27'd0, last5_addr}, 4);
        chk("t4_ovf", {31'd0, overflow5}, 1);
        chk("t4_pixcnt", {27'd0, pix_count5}, 5);
        chk("t4_fdone", fd5_total - f5, 1);

        // byte swap; overflow must clear at frame start
        byte_swap = 1'b1;
        b = wr_total;
        frame_start();
        chk("t4_ovf_clear", {31'd0, overflow5}, 0);
        send_line(8); send_line(8); send_line(8);
        frame_end();
        chk("t2_nwr", wr_total - b, 12);
        chk("t2_first", {16'd0, wd(b)}, 32'h0201);
        chk("t2_last", {16'd0, wd(b + 11)}, 32'h1817);

        // decimation over an oversized 6x4 frame
        byte_swap = 1'b0; decim = 1'b1;
        b = wr_total;
        frame_start();
        send_line(12); send_line(12); send_line(12); send_line(12);
        frame_end();
        chk("t3_nwr", wr_total - b, 4);
        chk("t3_pix0", {16'd0, wd(b)}, 32'h0102);
        chk("t3_pix1", {16'd0, wd(b + 1)}, 32'h0506);
        chk("t3_pix2", {16'd0, wd(b + 2)}, 32'h191A);
        chk("t3_pix3", {16'd0, wd(b + 3)}, 32'h1D1E);
        chk("t3_addr3", {27'd0, wa(b + 3)}, 3);
        chk("t3_pixcnt", {27'd0, pix_count}, 4);

        // odd-length line: trailing byte dropped, next line realigned
        decim = 1'b0;
        b = wr_total;
        frame_start();
        send_line(7); send_line(8); send_line(8);
        frame_end();
        chk("t5_nwr", wr_total - b, 11);
        chk("t5_pix2", {16'd0, wd(b + 2)}, 32'h0506);
        chk("t5_pix3", {16'd0, wd(b + 3)}, 32'h0809);
        chk("t5_pixcnt", {27'd0, pix_count}, 11);

        // enable dropped mid-frame: frame still completes, then IDLE
        b = wr_total; f = fd_total;
        frame_start();
        send_line(8);
        enable = 1'b0;
        send_line(8); send_line(8);
        frame_end();
        chk("t6_nwr", wr_total - b, 12);
        chk("t6_fdone", fd_total - f, 1);
        chk("t6_pixcnt", {27'd0, pix_count}, 12);
        chk("t6_busy", {31'd0, busy}, 0);

        // reset mid-frame: partial frame never reported
        enable = 1'b1;
        frame_start();
        send_line(4);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        chk("t6r_wr_en", {31'd0, wr_en}, 0);
        chk("t6r_wr_addr", {27'd0, wr_addr}, 0);
        chk("t6r_wr_data", {16'd0, wr_data}, 0);
        chk("t6r_fdone", {31'd0, frame_done}, 0);
        chk("t6r_pixcnt", {27'd0, pix_count}, 0);
        chk("t6r_busy", {31'd0, busy}, 0);
        b = wr_total; f = fd_total;
        @(negedge clk);
        rst_n = 1'b1;
        send_line(8);
        frame_end();
        chk("t6r_nwr", wr_total - b, 0);
        chk("t6r_nfdone", fd_total - f, 0);
        chk("t6r_pixcnt_end", {27'd0, pix_count}, 0);
        chk("t6r_ovf", {31'd0, overflow}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
